top_level: RTL and testbench
============================

// Module: top_level
// PURPOSE
// - Audio front end: receives 24-bit two's-complement stereo from the codec ADC (left-justified serial, BCLK/LRC from codec).
// - All logic runs on board clock MCLK; codec BCLK, LRC and ADC data are treated as asynchronous data inputs.
// - Left-channel level is peak-detected and driven to one LED-style PWM output, b.
// PARAMETERS
// - SAMPLE_W      24  data bits per channel word, MSB first
// - SLOT_W        32  BCLK periods per LRC half-period; bits beyond SAMPLE_W ignored
// - DATA_DELAY    0   BCLKs between LRC edge and MSB (0 = left-justified, 1 = I2S)
// - LEVEL_W       8   width of displayed level and PWM counter
// - DECAY_FRAMES  48  completed frames per 1-LSB peak decay
// PORTS
// - MCLK          in   1  system clock, 50 MHz
// - RESET         in   1  asynchronous, active-low reset
// - AUD_BCLK      in   1  codec bit clock; data valid on its rising edge
// - AUD_LRC       in   1  codec frame clock; 0 = left slot, 1 = right slot
// - AUD_ADC_DATA  in   1  codec serial data, changes on BCLK falling edge
// - b             out  1  PWM level indicator
// BEHAVIOUR
// - Reset: synchronizers, counters, samples, peak, PWM cleared; b = 0; receiver waits for an LRC edge.
// - BCLK, LRC, DATA each pass a 2-FF synchronizer. BCLK rise = sync BCLK 1 and previous 0.
// - At each BCLK rise: an LRC change vs the last sampled LRC sets bit_cnt = 0, channel = new LRC.
// - With DATA_DELAY 0, the bit sampled on that same edge is the MSB.
// - Bits bit_cnt = DATA_DELAY .. DATA_DELAY+SAMPLE_W-1 shift in MSB first. bit_cnt saturates at SLOT_W-1.
// - After the last bit, the word goes to left_s or right_s; a 1-MCLK valid pulse is raised. Latency = 1 MCLK after the capture edge.
// - LRC toggles before SAMPLE_W bits: partial word discarded, no valid pulse.
// - Bits before the first LRC edge after reset: discarded.
// - Magnitude = |left_s|. The value -2^23 saturates to 2^23-1.
// - level = mag[SAMPLE_W-2 -: LEVEL_W], so full scale gives 255.
// - Peak: on each left valid, if level > peak then peak = level.
// - Decay: every DECAY_FRAMES right-valid pulses, peak -= 1, floor 0. A rise takes precedence over a decay in the same cycle.
// - PWM: free-running LEVEL_W-bit counter on MCLK, wraps 255 -> 0. b registered: b = (pwm_cnt < peak).
// - peak = 0 gives b = 0 always; peak = 255 gives b high 255 of every 256 cycles.
// - Reset mid-frame: in-flight word dropped; PWM restarts at 0.
// CONFIGURATION
// - PEAK_HOLD_EN defined: peak hold plus decay as above.
// - PEAK_HOLD_EN undefined: peak = level of the latest left word, no decay logic. The PWM compare is unchanged.
// STRUCTURE
// - Package top_level_pkg: SAMPLE_W, SLOT_W, LEVEL_W constants; typedef sample_t (signed [23:0]); typedef level_t ([7:0]); enum chan_e {CH_L, CH_R}.
// - Sub-module i2s_rx: synchronizers, edge detect, bit counter, shift register. Outputs left_s, right_s, l_valid, r_valid.
// - top_level: i2s_rx, then magnitude, peak, PWM.
// TESTING
// - Reset held 5 BCLKs, released: b = 0; no valid pulse until the first LRC edge.
// - Left = 24'h7FFFFF, right = 0: l_valid 1 MCLK after the 24th bit; b high 255 of 256 MCLK.
// - Left = 24'h800000: magnitude saturates, level = 255, same duty as above.
// - Incrementing sample (frame n carries n) from 0: level stays 0, b stays 0.
// - Left 24'h400000 once, then 0 (PEAK_HOLD_EN): peak 128, then 127 after 48 frames; reaches 0 after 6144 frames.
// - LRC toggled after 10 bits: no valid pulse; the next full word is captured correctly.

Source files
------------

// File: rtl/top_level_pkg.sv
// ---------------------------------------------------------------------------
// top_level_pkg
// Shared constants, types and helpers for the audio level-meter front end.
// Contents:
//   SAMPLE_W, SLOT_W, DATA_DELAY, LEVEL_W, DECAY_FRAMES  - frame/level geometry
//   sample_t   - one signed codec word
//   level_t    - displayed level / PWM compare width
//   chan_e     - slot identity taken from LRC (0 = left, 1 = right)
//   rx_state_e - serial receiver synchronisation state
//   level_of() - saturating magnitude of a sample, reduced to display width
// ---------------------------------------------------------------------------
package top_level_pkg;

    localparam int SAMPLE_W     = 24;
    localparam int SLOT_W       = 32;
    localparam int DATA_DELAY   = 0;
    localparam int LEVEL_W      = 8;
    localparam int DECAY_FRAMES = 48;

    localparam int BIT_CNT_W    = $clog2(SLOT_W);
    localparam int DECAY_CNT_W  = $clog2(DECAY_FRAMES);

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [LEVEL_W-1:0]         level_t;

    typedef enum logic {
        CH_L = 1'b0,
        CH_R = 1'b1
    } chan_e;

    // RX_IDLE: no LRC reference yet; RX_WAIT: reference held, waiting for a
    // slot boundary; RX_RUN: aligned to slots and capturing words.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_WAIT,
        RX_RUN
    } rx_state_e;

    localparam sample_t SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam sample_t SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

    // The most negative code has no positive twin, so it is clamped to full
    // scale. The magnitude's sign bit is always zero, so the level is the
    // next LEVEL_W bits down; full scale therefore shows as all ones.
    function automatic level_t level_of(input sample_t s);
        logic [SAMPLE_W-1:0] mag;
        if (s == SAMPLE_MIN) begin
            mag = SAMPLE_MAX;
        end else if (s[SAMPLE_W-1]) begin
            mag = -s;
        end else begin
            mag = s;
        end
        return level_t'(mag >> (SAMPLE_W - 1 - LEVEL_W));
    endfunction

endpackage

// File: rtl/top_level_i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx
// Oversampled serial audio receiver. BCLK, LRC and DATA are asynchronous to
// clk and are brought in through two-flop synchronizers; all decoding is done
// on clk using a detected BCLK rising edge.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   bclk     in   codec bit clock (data valid on its rising edge)
//   lrc      in   codec frame clock, 0 = left slot, 1 = right slot
//   data     in   codec serial data, MSB first
//   left_s   out  last complete left word
//   right_s  out  last complete right word
//   l_valid  out  one-clk pulse when left_s has just been updated
//   r_valid  out  one-clk pulse when right_s has just been updated
// ---------------------------------------------------------------------------
module i2s_rx
    import top_level_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    bclk,
    input  logic    lrc,
    input  logic    data,
    output sample_t left_s,
    output sample_t right_s,
    output logic    l_valid,
    output logic    r_valid
);

    logic [1:0]           bclk_sync;
    logic [1:0]           lrc_sync;
    logic [1:0]           data_sync;
    logic                 bclk_prev;
    logic                 lrc_last;
    logic                 bclk_rise;
    logic                 lrc_change;
    logic                 capture;
    logic                 in_word;
    logic                 word_done;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] bit_idx;
    logic [SAMPLE_W-1:0]  shift_reg;
    logic [SAMPLE_W-1:0]  shift_next;
    chan_e                channel;
    chan_e                channel_now;
    rx_state_e            state;
    rx_state_e            state_next;
    int                   idx;

    // All three codec lines share the same synchronizer depth so that data
    // stays aligned with the bit clock edge that qualifies it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync <= '0;
            lrc_sync  <= '0;
            data_sync <= '0;
            bclk_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[0], bclk};
            lrc_sync  <= {lrc_sync[0], lrc};
            data_sync <= {data_sync[0], data};
            bclk_prev <= bclk_sync[1];
        end
    end

    assign bclk_rise  = bclk_sync[1] & ~bclk_prev;
    assign lrc_change = bclk_rise && (state != RX_IDLE) && (lrc_sync[1] != lrc_last);

    // Receiver alignment state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The first bit-clock edge after reset only records LRC, so a frame
    // already in progress at reset can never look like a slot boundary.
    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE: if (bclk_rise)  state_next = RX_WAIT;
            RX_WAIT: if (lrc_change) state_next = RX_RUN;
            RX_RUN:  state_next = RX_RUN;
            default: state_next = RX_IDLE;
        endcase
    end

    // A slot boundary restarts the bit index at zero on the same edge, so
    // with no data delay the bit sampled at the boundary is already the MSB.
    always_comb begin
        bit_idx     = lrc_change ? '0 : bit_cnt;
        channel_now = lrc_change ? chan_e'(lrc_sync[1]) : channel;
        idx         = int'(bit_idx);
        capture     = bclk_rise && (lrc_change || (state == RX_RUN));
        in_word     = (idx >= DATA_DELAY) && (idx < DATA_DELAY + SAMPLE_W);
        word_done   = capture && (idx == DATA_DELAY + SAMPLE_W - 1);
        shift_next  = {shift_reg[SAMPLE_W-2:0], data_sync[1]};
    end

    // Bit counter, shift register and word hand-off. A slot cut short by an
    // early LRC change never reaches the last bit index, so its partial word
    // is silently dropped when the counter restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lrc_last  <= 1'b0;
            bit_cnt   <= '0;
            channel   <= CH_L;
            shift_reg <= '0;
            left_s    <= '0;
            right_s   <= '0;
            l_valid   <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            l_valid <= 1'b0;
            r_valid <= 1'b0;
            if (bclk_rise) begin
                lrc_last <= lrc_sync[1];
            end
            if (capture) begin
                channel <= channel_now;
                if (in_word) begin
                    shift_reg <= shift_next;
                end
                if (bit_idx != BIT_CNT_W'(SLOT_W - 1)) begin
                    bit_cnt <= bit_idx + 1'b1;
                end else begin
                    bit_cnt <= bit_idx;
                end
                if (word_done) begin
                    if (channel_now == CH_L) begin
                        left_s  <= sample_t'(shift_next);
                        l_valid <= 1'b1;
                    end else begin
                        right_s <= sample_t'(shift_next);
                        r_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/top_level.sv
// ---------------------------------------------------------------------------
// top_level
// Audio front end: receives left-justified 24-bit stereo from the codec ADC,
// peak-detects the left channel and shows it as a PWM duty cycle on b.
// Ports:
//   MCLK          in   system clock, 50 MHz
//   RESET         in   asynchronous active-low reset
//   AUD_BCLK      in   codec bit clock (asynchronous)
//   AUD_LRC       in   codec frame clock (asynchronous), 0 = left slot
//   AUD_ADC_DATA  in   codec serial data (asynchronous)
//   b             out  PWM level indicator
// Configuration macro:
//   PEAK_HOLD_EN  defined   - peak holds the largest left level and decays by
//                             one step every DECAY_FRAMES right words
//                 undefined - peak simply follows the latest left level
// ---------------------------------------------------------------------------
module top_level
    import top_level_pkg::*;
(
    input  logic MCLK,
    input  logic RESET,
    input  logic AUD_BCLK,
    input  logic AUD_LRC,
    input  logic AUD_ADC_DATA,
    output logic b
);

    sample_t left_s;
    sample_t right_s_unused;
    logic    l_valid;
    logic    r_valid;
    level_t  level;
    level_t  peak;
    level_t  pwm_cnt;

    // The right word is received to keep frame framing and decay timing, but
    // is not itself displayed.
    i2s_rx u_rx (
        .clk     (MCLK),
        .rst_n   (RESET),
        .bclk    (AUD_BCLK),
        .lrc     (AUD_LRC),
        .data    (AUD_ADC_DATA),
        .left_s  (left_s),
        .right_s (right_s_unused),
        .l_valid (l_valid),
        .r_valid (r_valid)
    );

    assign level = level_of(left_s);

`ifdef PEAK_HOLD_EN
    logic [DECAY_CNT_W-1:0] decay_cnt;
    logic                   decay_tick;

    assign decay_tick = r_valid && (decay_cnt == DECAY_CNT_W'(DECAY_FRAMES - 1));

    // One right word closes each frame, so counting right words paces decay.
    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            decay_cnt <= '0;
        end else if (r_valid) begin
            decay_cnt <= decay_tick ? '0 : decay_cnt + 1'b1;
        end
    end

    // A new higher level wins over a decay step landing in the same cycle;
    // decay stops at zero.
    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            peak <= '0;
        end else if (l_valid && (level > peak)) begin
            peak <= level;
        end else if (decay_tick && (peak != '0)) begin
            peak <= peak - 1'b1;
        end
    end
`else
    // Without hold, the display tracks each new left word directly.
    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            peak <= '0;
        end else if (l_valid) begin
            peak <= level;
        end
    end
`endif

    // Free-running PWM: over any 256 consecutive cycles b is high exactly
    // peak times, so peak 0 is dark and full scale is high 255 of 256.
    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            pwm_cnt <= '0;
            b       <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            b       <= (pwm_cnt < peak);
        end
    end

endmodule

// File: tb/tb_top_level.sv
// ---------------------------------------------------------------------------
// tb_top_level
// Self-checking bench for top_level: drives left-justified serial frames with
// BCLK at a quarter of MCLK and compares the captured words, valid pulses,
// peak value and PWM duty against a behavioural level/peak model.
// ---------------------------------------------------------------------------
module tb_top_level;

    logic mclk = 1'b0;
    logic rst_n;
    logic aud_bclk;
    logic aud_lrc;
    logic aud_data;
    logic b;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int l_cnt = 0;
    int r_cnt = 0;
    int l_cyc = 0;
    int b_high = 0;
    int left_rise_cyc = 0;
    int model_peak = 0;
`ifdef PEAK_HOLD_EN
    int model_rcnt = 0;
`endif

    top_level dut (
        .MCLK         (mclk),
        .RESET        (rst_n),
        .AUD_BCLK     (aud_bclk),
        .AUD_LRC      (aud_lrc),
        .AUD_ADC_DATA (aud_data),
        .b            (b)
    );

    always #10 mclk = ~mclk;

    // Cycle stamp, advanced on the active edge and read on the falling edge.
    always @(posedge mclk) cyc <= cyc + 1;

    // Passive monitor: counts valid pulses (one count per high cycle) and
    // PWM high cycles.
    always @(negedge mclk) begin
        if (dut.l_valid) begin
            l_cnt <= l_cnt + 1;
            l_cyc <= cyc;
        end
        if (dut.r_valid) r_cnt <= r_cnt + 1;
        if (b) b_high <= b_high + 1;
    end

    // Watchdog so the run always ends.
    initial begin
        repeat (150000) @(posedge mclk);
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vec_cnt++;
        if (observed !== expected) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference level: saturating absolute value scaled to 0..255.
    function automatic int levelOf(input logic [23:0] x);
        int v;
        v = $signed(x);
        if (v < 0) v = -v;
        if (v > 8388607) v = 8388607;
        return v / 32768;
    endfunction

    task automatic modelLeft(input logic [23:0] x);
        int lv;
        lv = levelOf(x);
`ifdef PEAK_HOLD_EN
        if (lv > model_peak) model_peak = lv;
`else
        model_peak = lv;
`endif
    endtask

    task automatic modelRight();
`ifdef PEAK_HOLD_EN
        model_rcnt++;
        if (model_rcnt == 48) begin
            model_rcnt = 0;
            if (model_peak > 0) model_peak--;
        end
`endif
    endtask

    task automatic sendBit(input logic lrc_v, input logic bit_v);
        aud_bclk = 1'b0;
        aud_lrc  = lrc_v;
        aud_data = bit_v;
        repeat (2) @(negedge mclk);
        aud_bclk = 1'b1;
        repeat (2) @(negedge mclk);
    endtask

    // One slot of nbits bit clocks; bits past the sample word are junk.
    task automatic sendSlot(input logic lrc_v, input logic [23:0] word, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            logic bit_v;
            if (i < 24) bit_v = word[23-i];
            else        bit_v = 1'($urandom);
            aud_bclk = 1'b0;
            aud_lrc  = lrc_v;
            aud_data = bit_v;
            repeat (2) @(negedge mclk);
            aud_bclk = 1'b1;
            if (!lrc_v && i == 23) left_rise_cyc = cyc;
            repeat (2) @(negedge mclk);
        end
    endtask

    // Reset held for 5 bit clocks, then 4 bits in the right slot so the next
    // left slot starts on a genuine LRC edge.
    task automatic applyReset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) sendBit(1'b1, 1'($urandom));
        checkOutput("b_in_reset", {31'd0, b}, 32'd0);
        checkOutput("pwm_in_reset", {24'd0, dut.pwm_cnt}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) sendBit(1'b1, 1'($urandom));
        model_peak = 0;
`ifdef PEAK_HOLD_EN
        model_rcnt = 0;
`endif
    endtask

    // One full frame, then compare everything it should have produced.
    task automatic applyStimulus(input logic [23:0] left, input logic [23:0] right);
        int l0;
        int r0;
        l0 = l_cnt;
        r0 = r_cnt;
        sendSlot(1'b0, left, 32);
        sendSlot(1'b1, right, 32);
        repeat (4) @(negedge mclk);
        modelLeft(left);
        modelRight();
        checkOutput("l_valid_pulses", l_cnt - l0, 1);
        checkOutput("r_valid_pulses", r_cnt - r0, 1);
        checkOutput("l_latency", l_cyc - left_rise_cyc, 3);
        checkOutput("left_s", {8'd0, dut.left_s}, {8'd0, left});
        checkOutput("right_s", {8'd0, dut.u_rx.right_s}, {8'd0, right});
        checkOutput("peak", {24'd0, dut.peak}, model_peak);
    endtask

    // Idle the bit clock and count PWM high cycles over one full period.
    task automatic measureDuty(input string tag);
        int h0;
        aud_bclk = 1'b0;
        repeat (8) @(negedge mclk);
        h0 = b_high;
        repeat (256) @(negedge mclk);
        checkOutput(tag, b_high - h0, model_peak);
    endtask

    initial begin
        int h0;
        int l0;
        int r0;
        int exp_peak;
        logic [23:0] lw;
        logic [23:0] rw;

        rst_n    = 1'b0;
        aud_bclk = 1'b0;
        aud_lrc  = 1'b1;
        aud_data = 1'b0;
        @(negedge mclk);

        // Reset, then a long run without any LRC edge: nothing is captured.
        applyReset();
        for (int i = 0; i < 40; i++) sendBit(1'b1, 1'($urandom));
        repeat (4) @(negedge mclk);
        checkOutput("no_edge_l_valid", l_cnt, 0);
        checkOutput("no_edge_r_valid", r_cnt, 0);
        checkOutput("no_edge_b", {31'd0, b}, 32'd0);

        // Positive full scale.
        applyStimulus(24'h7FFFFF, 24'h000000);
        checkOutput("full_pos_peak", {24'd0, dut.peak}, 255);
        measureDuty("duty_full_pos");

        // Reset mid-frame: partial word dropped, peak and PWM cleared.
        l0 = l_cnt;
        sendSlot(1'b0, 24'h7FFFFF, 12);
        applyReset();
        repeat (4) @(negedge mclk);
        checkOutput("midreset_l_valid", l_cnt - l0, 0);
        checkOutput("midreset_peak", {24'd0, dut.peak}, 0);

        // Negative full scale saturates to the same level.
        applyStimulus(24'h800000, 24'h000000);
        checkOutput("full_neg_peak", {24'd0, dut.peak}, 255);
        measureDuty("duty_full_neg");

        // Incrementing tiny samples never light the indicator.
        applyReset();
        h0 = b_high;
        for (int n = 0; n < 16; n++) applyStimulus(24'(n), 24'(n));
        checkOutput("incr_b_high", b_high - h0, 0);
        measureDuty("duty_incr");

        // Half scale then silence: hold at 128, one step down after 48 frames.
        applyReset();
        applyStimulus(24'h400000, 24'h000000);
        checkOutput("half_peak", {24'd0, dut.peak}, 128);
        for (int n = 1; n < 48; n++) applyStimulus(24'h000000, 24'h000000);
`ifdef PEAK_HOLD_EN
        exp_peak = 127;
`else
        exp_peak = 0;
`endif
        checkOutput("decay_48", {24'd0, dut.peak}, exp_peak);
        measureDuty("duty_decay");

        // Level 1 decays to 0 and then stays at the floor.
        applyReset();
        applyStimulus(24'h008000, 24'h000000);
        for (int n = 1; n < 97; n++) applyStimulus(24'h000000, 24'h000000);
        checkOutput("decay_floor", {24'd0, dut.peak}, 0);

        // Left slot cut after 10 bits: no left word, next frame clean.
        applyReset();
        l0 = l_cnt;
        r0 = r_cnt;
        rw = 24'($urandom);
        sendSlot(1'b0, 24'h7FFFFF, 10);
        sendSlot(1'b1, rw, 32);
        repeat (4) @(negedge mclk);
        modelRight();
        checkOutput("partial_l_valid", l_cnt - l0, 0);
        checkOutput("partial_r_valid", r_cnt - r0, 1);
        checkOutput("partial_right_s", {8'd0, dut.u_rx.right_s}, {8'd0, rw});
        checkOutput("partial_peak", {24'd0, dut.peak}, model_peak);
        applyStimulus(24'h123456, 24'h654321);

        // Random frames over a spread of magnitudes and signs.
        applyReset();
        for (int n = 0; n < 30; n++) begin
            lw = 24'($urandom) >> $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1) lw = -lw;
            rw = 24'($urandom);
            applyStimulus(lw, rw);
            if (n % 10 == 9) measureDuty("duty_random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
